probe_display_mux: RTL and testbench
====================================

# probe_display_mux

Parametrised debug display controller for the single-cycle processor. It selects one of CHANNELS probe words (PC, instruction, register read data, ALU result, …) and one hex page of that word, and time-multiplexes it onto a DIGITS-wide seven-segment display. Beyond plain switch selection, it adds tear-free frame-boundary sampling, an auto-scan mode and a freeze snapshot. It sits in the top level between the processor datapath probe wires and the board display pins.

## Interface
- CHANNELS, 8, number of probe words on probe_bus
- DATA_W, 32, width of each probe word; must be a multiple of 4*DIGITS
- DIGITS, 4, number of display digits
- REFRESH_DIV, 50000, clk cycles each digit is lit
- DWELL_FRAMES, 250, frames shown per window in auto mode
- SEL_W, $clog2(CHANNELS), derived, channel select width
- PAGES, DATA_W/(4*DIGITS), derived; PAGE_W = max(1,$clog2(PAGES))

Ports:
- clk  in  1  display clock
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- probe_bus  in  CHANNELS*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- sel  in  SEL_W  manual channel select
- page  in  PAGE_W  manual page select; page p = bits [p*4*DIGITS +: 4*DIGITS]
- auto_scan  in  1  level; 1 = auto-scan mode
- freeze  in  1  level; 1 = hold snapshot
- seven_segment  out  7  active-low segments {g,f,e,d,c,b,a}
- anode  out  DIGITS  active-low one-cold digit enable; anode[0] = least-significant nibble
- cur_channel  out  SEL_W  channel of the displayed window
- cur_page  out  PAGE_W  page of the displayed window
- frozen  out  1  1 while snapshot displayed

## Operation
- refresh_cnt counts 0..REFRESH_DIV-1. At terminal count, digit_idx advances 0..DIGITS-1 and wraps. Frame start = digit_idx wraps to 0.
- Window register (4*DIGITS bits), cur_channel and cur_page update only at frame start. Displayed data never changes mid-frame.
- Manual mode (auto_scan=0): at frame start load sel/page and the selected slice. Out-of-range sel (>= CHANNELS) or page (>= PAGES) loads all-zero nibbles; cur_channel/cur_page still reflect the requested values.
- Auto mode (auto_scan=1): dwell_cnt counts frames. After DWELL_FRAMES frames, advance page first, then channel: (c,p)→(c,p+1); (c,PAGES-1)→(c+1,0); (CHANNELS-1,PAGES-1)→(0,0). Entering auto starts from the current cur_channel/cur_page with dwell_cnt=0. The live slice is reloaded every frame start.
- Freeze FSM, states LIVE and FROZEN:
  - LIVE→FROZEN on a freeze 0→1 edge (detected against the registered previous value). The current window register is held; dwell_cnt is paused.
  - FROZEN→LIVE when freeze=0. Sampling resumes at the next frame start.
  - Freeze overrides auto_scan. Mode changes while FROZEN take effect after release.
- Hex decode (active-low): 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; the remaining values follow the standard 0–F pattern.

## Timing
- Reset (reset=0 at a clk edge), all outputs registered:
  - anode = all ones, seven_segment = 1111111, frozen = 0, cur_channel = 0, cur_page = 0.
  - refresh_cnt, digit_idx, dwell_cnt and window are all 0; FSM = LIVE.
- First cycle after reset release: anode = ~1 with the digit-0 nibble decoded. The window loads channel 0, page 0 at that cycle (reset exit counts as frame start).
- anode and seven_segment change together, one cycle after the digit_idx/refresh_cnt update.
- Selection latency: a sel/page change appears at the next frame start, at most DIGITS*REFRESH_DIV cycles later.
- frozen asserts the cycle after the freeze edge and deasserts the cycle after freeze=0.
- Reset asserted mid-frame or while FROZEN: reset values apply on the next edge.
- Auto advance and a freeze edge in the same cycle: freeze wins; no advance occurs.

## Configuration
- PROBE_DISP_LZB_EN defined: leading-zero blanking. Zero nibbles above the most-significant non-zero nibble drive seven_segment = 1111111, and their anode remains active. An all-zero window shows only digit 0 as "0".
- Undefined: all DIGITS digits always show their hex value, including leading zeros.

## Test plan
Bench parameters: CHANNELS=4, DATA_W=32, DIGITS=4, REFRESH_DIV=4, DWELL_FRAMES=2.

- Reset: hold reset=0 for 3 cycles → anode=1111, seven_segment=1111111, frozen=0. On release, anode=1110 for 4 cycles, then 1101, 1011, 0111, then repeat.
- Manual select: channel 2 = 32'h1234ABCF, sel=2, page=1 → after the next frame start, digits 3..0 show 1,2,3,4. With page=0 the next frame shows A,B,C,F; digit 0 segments = 0001110.
- Mid-frame change: switch sel while digit_idx=2 → current frame completes with old data; new data appears at the next anode=1110.
- Auto scan: auto_scan=1 from (0,0) → windows (0,1),(1,0),…,(3,1),(0,0), each held exactly 2 frames = 32 cycles.
- Freeze: freeze rises during auto at (1,0); change probe_bus channel 1 → frozen=1 next cycle, display unchanged, no advance. Drop freeze → live data at the next frame start, and the dwell count resumes.
- LZB: window 16'h0040 with macro defined → digits 3 and 2 blank, digit 1 shows 4, digit 0 shows 0. Without the macro → shows 0040.

Source files
------------

// File: rtl/probe_display_mux.sv
// Debug display controller: picks one probe word and one hex page, then scans it onto a
// multiplexed seven-segment display. Define PROBE_DISP_LZB_EN for leading-zero blanking.
module probe_display_mux #(
  parameter int CHANNELS     = 8,
  parameter int DATA_W       = 32,
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int DWELL_FRAMES = 250,
  localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PAGES  = DATA_W / (4 * DIGITS),
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*DATA_W-1:0]   probe_bus,
  input  logic [SEL_W-1:0]             sel,
  input  logic [PAGE_W-1:0]            page,
  input  logic                         auto_scan,
  input  logic                         freeze,
  output logic [6:0]                   seven_segment,
  output logic [DIGITS-1:0]            anode,
  output logic [SEL_W-1:0]             cur_channel,
  output logic [PAGE_W-1:0]            cur_page,
  output logic                         frozen
);

  localparam int WIN_W   = 4 * DIGITS;
  localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  typedef enum logic [0:0] {
    LIVE   = 1'b0,
    FROZEN = 1'b1
  } frz_state_t;

  frz_state_t          state_r, state_s;
  logic [REF_W-1:0]    refresh_cnt_r;
  logic [DIG_W-1:0]    digit_idx_r;
  logic [DWELL_W-1:0]  dwell_cnt_r, dwell_s;
  logic [WIN_W-1:0]    window_r, window_s;
  logic [SEL_W-1:0]    chan_s;
  logic [PAGE_W-1:0]   page_s;
  logic                auto_active_r, auto_active_s;
  logic                freeze_q_r;
  logic                frame_tick_s, freeze_rise_s, load_s;
  logic [3:0]          nibble_s;
  logic                blank_s;

  // Active-low hex to {g,f,e,d,c,b,a} decode.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Out-of-range channel or page yields an all-zero window.
  function automatic logic [WIN_W-1:0] slice_of(input logic [CHANNELS*DATA_W-1:0] bus,
                                                input logic [SEL_W-1:0] c,
                                                input logic [PAGE_W-1:0] p);
    logic [WIN_W-1:0] res;
    res = '0;
    for (int ci = 0; ci < CHANNELS; ci++) begin
      for (int pi = 0; pi < PAGES; pi++) begin
        res = (c == SEL_W'(ci) && p == PAGE_W'(pi)) ? bus[ci*DATA_W + pi*WIN_W +: WIN_W] : res;
      end
    end
    return res;
  endfunction

  // Refresh prescaler and digit scan counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= '0;
    end else if (refresh_cnt_r == REF_W'(REFRESH_DIV - 1)) begin
      refresh_cnt_r <= '0;
      if (digit_idx_r == DIG_W'(DIGITS - 1)) begin
        digit_idx_r <= '0;
      end else begin
        digit_idx_r <= digit_idx_r + DIG_W'(1);
      end
    end else begin
      refresh_cnt_r <= refresh_cnt_r + REF_W'(1);
      digit_idx_r   <= digit_idx_r;
    end
  end

  // Frame-start strobe: the cycle whose edge lights digit 0 (also the first cycle out of reset).
  always_comb begin
    frame_tick_s  = (refresh_cnt_r == '0) && (digit_idx_r == '0);
    freeze_rise_s = freeze && !freeze_q_r;
    load_s        = frame_tick_s && (state_r == LIVE) && !freeze_rise_s;
  end

  // Freeze FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      LIVE: begin
        if (freeze_rise_s) state_s = FROZEN;
        else               state_s = LIVE;
      end
      FROZEN: begin
        if (!freeze) state_s = LIVE;
        else         state_s = FROZEN;
      end
      default: state_s = LIVE;
    endcase
  end

  // Window selection: manual load, or auto-scan dwell/advance (page first, then channel).
  always_comb begin
    chan_s        = cur_channel;
    page_s        = cur_page;
    dwell_s       = dwell_cnt_r;
    auto_active_s = auto_active_r;
    window_s      = window_r;
    if (load_s) begin
      auto_active_s = auto_scan;
      if (!auto_scan) begin
        chan_s  = sel;
        page_s  = page;
        dwell_s = '0;
      end else if (!auto_active_r) begin
        dwell_s = '0;
      end else if (dwell_cnt_r == DWELL_W'(DWELL_FRAMES - 1)) begin
        dwell_s = '0;
        if (cur_page >= PAGE_W'(PAGES - 1)) begin
          page_s = '0;
          if (cur_channel >= SEL_W'(CHANNELS - 1)) chan_s = '0;
          else                                     chan_s = cur_channel + SEL_W'(1);
        end else begin
          page_s = cur_page + PAGE_W'(1);
        end
      end else begin
        dwell_s = dwell_cnt_r + DWELL_W'(1);
      end
      window_s = slice_of(probe_bus, chan_s, page_s);
    end else begin
      window_s = window_r;
    end
  end

  // Digit nibble and blanking; decoded from the window value that is current at the output edge.
  always_comb begin
    nibble_s = 4'h0;
    blank_s  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nibble_s = (digit_idx_r == DIG_W'(i)) ? window_s[i*4 +: 4] : nibble_s;
    end
`ifdef PROBE_DISP_LZB_EN
    for (int i = 1; i < DIGITS; i++) begin
      blank_s = (digit_idx_r == DIG_W'(i)) ? ((window_s >> (4 * i)) == '0) : blank_s;
    end
`else
    blank_s = 1'b0;
`endif
  end

  // Window, selection and freeze state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= LIVE;
      freeze_q_r    <= 1'b0;
      window_r      <= '0;
      dwell_cnt_r   <= '0;
      auto_active_r <= 1'b0;
      cur_channel   <= '0;
      cur_page      <= '0;
    end else begin
      state_r       <= state_s;
      freeze_q_r    <= freeze;
      window_r      <= window_s;
      dwell_cnt_r   <= dwell_s;
      auto_active_r <= auto_active_s;
      cur_channel   <= chan_s;
      cur_page      <= page_s;
    end
  end

  // Registered display pins; anode follows digit_idx by one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      anode         <= '1;
      seven_segment <= 7'h7F;
      frozen        <= 1'b0;
    end else begin
      anode         <= ~(DIGITS'(1) << digit_idx_r);
      seven_segment <= blank_s ? 7'h7F : hex7(nibble_s);
      frozen        <= (state_s == FROZEN);
    end
  end

endmodule

// File: tb/tb_probe_display_mux.sv
// Self-checking bench for probe_display_mux: vector table, directed corner sequences and
// randomized traffic against a cycle-count based reference model.
module tb_probe_display_mux;

  localparam int CHANNELS     = 4;
  localparam int DATA_W       = 32;
  localparam int DIGITS       = 4;
  localparam int REFRESH_DIV  = 4;
  localparam int DWELL_FRAMES = 2;
  localparam int PAGES        = DATA_W / (4 * DIGITS);
  localparam int FRAME        = DIGITS * REFRESH_DIV;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

`ifdef PROBE_DISP_LZB_EN
  localparam logic [6:0] LZ = 7'b1111111;
  localparam bit LZB = 1'b1;
`else
  localparam logic [6:0] LZ = 7'b1000000;
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset;
  logic [CHANNELS*DATA_W-1:0] probe_bus;
  logic [1:0]                 sel;
  logic [0:0]                 page;
  logic                       auto_scan, freeze;
  logic [6:0]                 seven_segment;
  logic [DIGITS-1:0]          anode;
  logic [1:0]                 cur_channel;
  logic [0:0]                 cur_page;
  logic                       frozen;
  logic [31:0]                probe_w [CHANNELS];

  assign probe_bus = {probe_w[3], probe_w[2], probe_w[1], probe_w[0]};

  probe_display_mux #(
    .CHANNELS(CHANNELS), .DATA_W(DATA_W), .DIGITS(DIGITS),
    .REFRESH_DIV(REFRESH_DIV), .DWELL_FRAMES(DWELL_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .probe_bus(probe_bus), .sel(sel), .page(page),
    .auto_scan(auto_scan), .freeze(freeze), .seven_segment(seven_segment),
    .anode(anode), .cur_channel(cur_channel), .cur_page(cur_page), .frozen(frozen)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_t, m_ch, m_pg, m_shown;
  bit         m_frozen, m_prev, m_auto_seen;
  logic [15:0] m_win;
  logic [3:0] e_anode;
  logic [6:0] e_seg;
  logic       e_frozen;
  int         e_ch, e_pg;

  typedef struct {
    logic [31:0]      word;
    int               ch;
    int               pg;
    logic [3:0][6:0]  seg;   // seg[d] expected on digit d
  } vec_t;
  vec_t tbl [6];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] ref_slice(int ch, int pg);
    logic [31:0] w;
    if (ch >= CHANNELS || pg >= PAGES) return 16'h0000;
    w = probe_w[ch] >> (16 * pg);
    return w[15:0];
  endfunction

  // Expected state after one rising edge, from the inputs present at that edge.
  function automatic void model_edge();
    int digit, nib, msd, idx;
    bit rise;
    if (!reset) begin
      m_t = 0; m_frozen = 1'b0; m_prev = 1'b0; m_auto_seen = 1'b0; m_shown = 0;
      m_ch = 0; m_pg = 0; m_win = 16'h0000;
      e_anode = 4'hF; e_seg = 7'h7F; e_frozen = 1'b0; e_ch = 0; e_pg = 0;
      return;
    end
    digit = (m_t / REFRESH_DIV) % DIGITS;
    rise  = freeze && !m_prev;
    if ((m_t % FRAME) == 0 && !m_frozen && !rise) begin
      if (!auto_scan) begin
        m_ch = int'(sel); m_pg = int'(page); m_auto_seen = 1'b0;
      end else if (!m_auto_seen) begin
        m_auto_seen = 1'b1; m_shown = 1;
      end else if (m_shown >= DWELL_FRAMES) begin
        idx = (m_ch * PAGES + m_pg + 1) % (CHANNELS * PAGES);
        m_ch = idx / PAGES; m_pg = idx % PAGES; m_shown = 1;
      end else begin
        m_shown++;
      end
      m_win = ref_slice(m_ch, m_pg);
    end
    if (!m_frozen && rise) m_frozen = 1'b1;
    else if (m_frozen && !freeze) m_frozen = 1'b0;
    m_prev = freeze;
    m_t++;
    nib = int'((m_win >> (4 * digit)) & 16'h000F);
    msd = 0;
    for (int i = 0; i < DIGITS; i++) if (((m_win >> (4 * i)) & 16'h000F) != 16'h0) msd = i;
    e_anode  = ~(4'b0001 << digit);
    e_seg    = (LZB && digit > msd) ? 7'h7F : HEX[nib];
    e_frozen = m_frozen;
    e_ch     = m_ch;
    e_pg     = m_pg;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("anode", 32'(anode), 32'(e_anode));
    chk("seg", 32'(seven_segment), 32'(e_seg));
    chk("frozen", 32'(frozen), 32'(e_frozen));
    chk("cur_channel", 32'(cur_channel), 32'(e_ch));
    chk("cur_page", 32'(cur_page), 32'(e_pg));
  endtask

  // Advance to the first cycle of the next frame (digit 0 lit with the new window).
  task automatic go_frame();
    while ((m_t % FRAME) != 0) step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_an;
    int idx;

    tbl[0] = '{32'h1234ABCF, 2, 1, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tbl[1] = '{32'h1234ABCF, 2, 0, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0001110}};
    tbl[2] = '{32'h56789E0D, 3, 0, {7'b0010000, 7'b0000110, 7'b1000000, 7'b0100001}};
    tbl[3] = '{32'h56789E0D, 3, 1, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
    tbl[4] = '{32'h00000040, 0, 0, {LZ, LZ, 7'b0011001, 7'b1000000}};
    tbl[5] = '{32'h00000040, 0, 1, {LZ, LZ, LZ, 7'b1000000}};

    probe_w[0] = 32'hC0DE_0001; probe_w[1] = 32'h1111_2222;
    probe_w[2] = 32'h3333_4444; probe_w[3] = 32'h5555_6666;
    reset = 1'b0; sel = 2'd0; page = 1'b0; auto_scan = 1'b0; freeze = 1'b0;

    // Reset hold and scan order after release
    repeat (3) step();
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(seven_segment), 32'h7F);
    chk("rst_frozen", 32'(frozen), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      exp_an = ~(4'b0001 << ((i / REFRESH_DIV) % DIGITS));
      chk("anode_seq", 32'(anode), 32'(exp_an));
    end

    // Vector table: manual channel/page selection and hex decode
    for (int i = 0; i < 6; i++) begin
      probe_w[tbl[i].ch] = tbl[i].word;
      sel  = 2'(tbl[i].ch);
      page = 1'(tbl[i].pg);
      go_frame();
      for (int d = 0; d < DIGITS; d++) begin
        chk("tbl_seg", 32'(seven_segment), 32'(tbl[i].seg[d]));
        chk("tbl_ch", 32'(cur_channel), 32'(tbl[i].ch));
        repeat (REFRESH_DIV) step();
      end
    end

    // Mid-frame selection change is deferred to the next frame
    sel = 2'd2; page = 1'b0;
    go_frame();
    repeat (2 * REFRESH_DIV) step();
    sel = 2'd3;
    repeat (REFRESH_DIV) step();
    chk("mid_hold", 32'(cur_channel), 32'd2);
    go_frame();
    chk("mid_new", 32'(cur_channel), 32'd3);
    chk("mid_anode", 32'(anode), 32'hE);

    // Auto scan from (0,0), each window held DWELL_FRAMES frames, full wrap
    sel = 2'd0; page = 1'b0;
    go_frame();
    auto_scan = 1'b1;
    for (int k = 0; k < 18; k++) begin
      go_frame();
      idx = (k / DWELL_FRAMES) % (CHANNELS * PAGES);
      chk("auto_ch", 32'(cur_channel), 32'(idx / PAGES));
      chk("auto_pg", 32'(cur_page), 32'(idx % PAGES));
    end

    // Freeze at (1,0): no advance, held display, then resume with live data
    repeat (3) go_frame();
    chk("frz_pre_ch", 32'(cur_channel), 32'd1);
    chk("frz_pre_pg", 32'(cur_page), 32'd0);
    repeat (5) step();
    freeze = 1'b1;
    step();
    chk("frz_edge", 32'(frozen), 32'd1);
    probe_w[1] = 32'h0000_0007;
    repeat (40) step();
    chk("frz_ch", 32'(cur_channel), 32'd1);
    chk("frz_pg", 32'(cur_page), 32'd0);
    freeze = 1'b0;
    step();
    chk("frz_release", 32'(frozen), 32'd0);
    go_frame();
    chk("resume_ch", 32'(cur_channel), 32'd1);
    chk("resume_pg", 32'(cur_page), 32'd0);
    chk("resume_seg", 32'(seven_segment), 32'(7'b1111000));
    go_frame();
    chk("resume_adv", 32'(cur_page), 32'd1);

    // Randomized traffic including mid-frame resets and freeze toggles
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 49) == 0)
        probe_w[$urandom_range(0, CHANNELS - 1)] = $urandom;
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) page = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) auto_scan = ~auto_scan;
      if ($urandom_range(0, 59) == 0) freeze = ~freeze;
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
